bicubic_weight_gen: RTL
=======================

// Module: bicubic_weight_gen
// PURPOSE
//  Generates all four bicubic tap weights W0..W3 for one fractional phase t in [0,1)
//  and a runtime sharpness A (a = -A). Taps sit at distances 1+t, t, 1-t, 2-t.
//  Streaming valid/ready pipeline feeding the 4-tap horizontal/vertical interpolators.
//  Adds a bilinear mode, sum normalisation and back-pressure.
// PARAMETERS
//  FRAC_W  8   fractional bits of t, A and weights (ONE = 2**FRAC_W)
//  COEF_W  10  signed weight width (>= FRAC_W+2)
//  NORM    1   1: W3 = ONE-(W0+W1+W2) so the weights sum to ONE; 0: W3 computed directly
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         synchronous active-low reset
//  in_valid   in   1         phase/A/mode valid
//  in_ready   out  1         block accepts input this cycle
//  in_t       in   FRAC_W    unsigned phase t, Q0.FRAC_W
//  in_a       in   FRAC_W+1  unsigned A, Q1.FRAC_W (0 <= A < 2)
//  in_mode    in   1         0 bicubic, 1 bilinear
//  out_valid  out  1         weights valid
//  out_ready  in   1         downstream accepts weights
//  out_w0..3  out  COEF_W    signed weights, Q.FRAC_W, two's complement
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): out_valid=0, out_w0..3=0, all stage valids cleared.
//   In-flight data dropped. in_ready=1 during reset.
//  Handshake: adv = !out_valid | out_ready; in_ready = adv (combinational).
//   Transfer happens when in_valid & in_ready.
//   One pipeline enable: all 4 stages shift only on adv. Bubbles shift as invalid.
//   With out_valid=1 & out_ready=0, outputs and all stages hold stable.
//  Latency: exactly 4 clk from input transfer to out_valid when adv stays 1.
//   Throughput 1 weight set per clk.
//  S1: register t, A, mode and the distances d0=ONE+t, d1=t, d2=ONE-t, d3=2*ONE-t.
//  S2: d^2 for each tap at full precision (2*FRAC_W frac bits).
//  S3: d^3 and A products, full precision (no truncation).
//  S4: weights, then round, saturate and register.
//   near (d1,d2): (2-A)d^3 - (3-A)d^2 + 1
//   far (d0,d3): -A*d^3 + 5A*d^2 - 8A*d + 4A
//  Rounding: add half-LSB of the target grid, arithmetic shift to FRAC_W frac bits
//   (round half toward +inf).
//  Saturation: clamp to [-2**(COEF_W-1), 2**(COEF_W-1)-1]. No wrap allowed.
//  Bilinear mode: W0=0, W1=ONE-t, W2=t, W3=0. Same latency. A ignored.
//  NORM=1: W3 = ONE-(W0+W1+W2) after rounding/saturation of W0..W2, then saturated.
//   Applied in bicubic mode only.
//  t=0 boundary: W1=ONE, others 0 in both modes. in_t cannot represent t=1.
//  A=0: far weights 0. Near weights reduce to 2d^3-3d^2+1.
//  Reset asserted with in_valid=1: input is not accepted.
// TESTING (FRAC_W=8, COEF_W=10, NORM=1, out_ready=1 unless stated)
//  t=0, A=128, bicubic -> 4 clk later W={0,256,0,0}, out_valid 1 clk.
//  t=128, A=128 -> W={-16,144,144,-16}. t=64, A=128 -> W={-18,222,58,-6}, sum=256.
//  t=128, A=0 -> W={0,128,128,0}. t=64, mode=1 -> W={0,192,64,0}.
//  Back-to-back t=0,64,128 on 3 clks, out_ready low 5 clks after first out_valid
//   -> in_ready low, W held, then three sets in order, one per clk, none lost or duplicated.
//  Sweep t=0..255 x A in {0,64,128,192,256} vs golden model -> exact match, sum=256 when NORM=1.
//  rst_n low 1 clk while 3 sets in flight -> out_valid=0, W=0, no stale set afterwards.

Source files
------------

// File: rtl/bicubic_weight_gen.sv
// ---------------------------------------------------------------------------
// bicubic_weight_gen
//   Produces the four bicubic tap weights W0..W3 for one fractional phase t
//   and a runtime sharpness A (kernel parameter a = -A). Taps sit at
//   distances 1+t, t, 1-t and 2-t. A bilinear mode bypasses the cubic kernel.
//   Four-stage valid/ready pipeline with a single shared advance enable.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   phase/A/mode valid
//   in_ready   block accepts input this cycle (combinational)
//   in_t       unsigned phase t, Q0.FRAC_W
//   in_a       unsigned sharpness A, Q1.FRAC_W
//   in_mode    0 bicubic, 1 bilinear
//   out_valid  weights valid
//   out_ready  downstream accepts weights
//   out_w0..3  signed weights, FRAC_W fractional bits
// ---------------------------------------------------------------------------
module bicubic_weight_gen #(
  parameter int FRAC_W = 8,
  parameter int COEF_W = 10,
  parameter bit NORM   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FRAC_W-1:0]        in_t,
  input  logic [FRAC_W:0]          in_a,
  input  logic                     in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [COEF_W-1:0] out_w0,
  output logic signed [COEF_W-1:0] out_w1,
  output logic signed [COEF_W-1:0] out_w2,
  output logic signed [COEF_W-1:0] out_w3
);

  // Distances reach 2*ONE, so they need two integer bits.
  localparam int DW    = FRAC_W + 2;
  localparam int AW    = FRAC_W + 1;
  localparam int SQW   = 2 * DW;
  localparam int CUW   = 3 * DW;
  localparam int ACW   = AW + 3 * DW;
  localparam int ASW   = AW + 2 * DW;
  localparam int ALW   = AW + DW;
  // Weight polynomials are evaluated on a common grid of 4*FRAC_W fraction bits.
  localparam int ACC_W = 4 * FRAC_W + 10;

  localparam logic [DW-1:0] ONE_D = {2'b01, {FRAC_W{1'b0}}};
  localparam logic [DW-1:0] TWO_D = {2'b10, {FRAC_W{1'b0}}};
  localparam logic [3:0]    NEAR_MASK = 4'b0110;

  localparam logic signed [ACC_W-1:0] ONE_ACC  = ACC_W'(32'd1) << FRAC_W;
  localparam logic signed [ACC_W-1:0] HALF_ACC = ACC_W'(32'd1) << (3 * FRAC_W - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI   = (ACC_W'(32'd1) << (COEF_W - 1)) - ACC_W'(32'd1);
  localparam logic signed [ACC_W-1:0] SAT_LO   = -(ACC_W'(32'd1) << (COEF_W - 1));

  // Full-precision kernel value at 4*FRAC_W fraction bits.
  //   near: 2d^3 - 3d^2 + 1 - A*d^3 + A*d^2
  //   far : -A*d^3 + 5A*d^2 - 8A*d + 4A
  function automatic logic signed [ACC_W-1:0] poly(
    input logic           near,
    input logic [CUW-1:0] cube,
    input logic [SQW-1:0] sq,
    input logic [ACW-1:0] acube,
    input logic [ASW-1:0] asq,
    input logic [ALW-1:0] alin,
    input logic [AW-1:0]  a
  );
    logic signed [ACC_W-1:0] acc;
    if (near) begin
      acc = (ACC_W'(cube) << (FRAC_W + 1))
          - ACC_W'(32'd3) * (ACC_W'(sq) << (2 * FRAC_W))
          + (ACC_W'(32'd1) << (4 * FRAC_W))
          - ACC_W'(acube)
          + (ACC_W'(asq) << FRAC_W);
    end else begin
      acc = ACC_W'(32'd5) * (ACC_W'(asq) << FRAC_W)
          - ACC_W'(acube)
          - (ACC_W'(alin) << (2 * FRAC_W + 3))
          + (ACC_W'(a) << (3 * FRAC_W + 2));
    end
    return acc;
  endfunction

  // Clamp to the signed output range; never wraps.
  function automatic logic signed [COEF_W-1:0] sat(input logic signed [ACC_W-1:0] x);
    logic signed [COEF_W-1:0] r;
    if (x > SAT_HI) begin
      r = SAT_HI[COEF_W-1:0];
    end else if (x < SAT_LO) begin
      r = SAT_LO[COEF_W-1:0];
    end else begin
      r = x[COEF_W-1:0];
    end
    return r;
  endfunction

  // Round half toward +inf onto the FRAC_W grid, then saturate.
  function automatic logic signed [COEF_W-1:0] round_sat(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] r;
    r = x + HALF_ACC;
    r = r >>> (3 * FRAC_W);
    return sat(r);
  endfunction

  logic adv_s;

  logic              s1_v_r, s1_mode_r;
  logic [FRAC_W-1:0] s1_t_r;
  logic [AW-1:0]     s1_a_r;
  logic [DW-1:0]     s1_d_r [4];

  logic              s2_v_r, s2_mode_r;
  logic [FRAC_W-1:0] s2_t_r;
  logic [AW-1:0]     s2_a_r;
  logic [DW-1:0]     s2_d_r  [4];
  logic [SQW-1:0]    s2_sq_r [4];

  logic              s3_v_r, s3_mode_r;
  logic [FRAC_W-1:0] s3_t_r;
  logic [AW-1:0]     s3_a_r;
  logic [CUW-1:0]    s3_cube_r  [4];
  logic [SQW-1:0]    s3_sq_r    [4];
  logic [ACW-1:0]    s3_acube_r [4];
  logic [ASW-1:0]    s3_asq_r   [4];
  logic [ALW-1:0]    s3_alin_r  [4];

  logic signed [COEF_W-1:0] w_s [4];

  // Whole pipeline moves together whenever the output slot is free or drained.
  assign adv_s    = ~out_valid | out_ready;
  assign in_ready = adv_s | ~rst_n;

  // Stage 1: capture inputs and the four tap distances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_r    <= 1'b0;
      s1_mode_r <= 1'b0;
      s1_t_r    <= '0;
      s1_a_r    <= '0;
      for (int i = 0; i < 4; i++) s1_d_r[i] <= '0;
    end else if (adv_s) begin
      s1_v_r    <= in_valid;
      s1_mode_r <= in_mode;
      s1_t_r    <= in_t;
      s1_a_r    <= in_a;
      s1_d_r[0] <= ONE_D + DW'(in_t);
      s1_d_r[1] <= DW'(in_t);
      s1_d_r[2] <= ONE_D - DW'(in_t);
      s1_d_r[3] <= TWO_D - DW'(in_t);
    end
  end

  // Stage 2: squares of the distances at full precision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_v_r    <= 1'b0;
      s2_mode_r <= 1'b0;
      s2_t_r    <= '0;
      s2_a_r    <= '0;
      for (int i = 0; i < 4; i++) begin
        s2_d_r[i]  <= '0;
        s2_sq_r[i] <= '0;
      end
    end else if (adv_s) begin
      s2_v_r    <= s1_v_r;
      s2_mode_r <= s1_mode_r;
      s2_t_r    <= s1_t_r;
      s2_a_r    <= s1_a_r;
      for (int i = 0; i < 4; i++) begin
        s2_d_r[i]  <= s1_d_r[i];
        s2_sq_r[i] <= SQW'(s1_d_r[i]) * SQW'(s1_d_r[i]);
      end
    end
  end

  // Stage 3: cubes and all A-scaled products, untruncated.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_v_r    <= 1'b0;
      s3_mode_r <= 1'b0;
      s3_t_r    <= '0;
      s3_a_r    <= '0;
      for (int i = 0; i < 4; i++) begin
        s3_cube_r[i]  <= '0;
        s3_sq_r[i]    <= '0;
        s3_acube_r[i] <= '0;
        s3_asq_r[i]   <= '0;
        s3_alin_r[i]  <= '0;
      end
    end else if (adv_s) begin
      s3_v_r    <= s2_v_r;
      s3_mode_r <= s2_mode_r;
      s3_t_r    <= s2_t_r;
      s3_a_r    <= s2_a_r;
      for (int i = 0; i < 4; i++) begin
        s3_cube_r[i]  <= CUW'(s2_sq_r[i]) * CUW'(s2_d_r[i]);
        s3_sq_r[i]    <= s2_sq_r[i];
        s3_acube_r[i] <= ACW'(s2_a_r) * ACW'(s2_sq_r[i]) * ACW'(s2_d_r[i]);
        s3_asq_r[i]   <= ASW'(s2_a_r) * ASW'(s2_sq_r[i]);
        s3_alin_r[i]  <= ALW'(s2_a_r) * ALW'(s2_d_r[i]);
      end
    end
  end

  // Stage 4 combinational: kernel evaluation, rounding, saturation, normalisation.
  always_comb begin
    for (int i = 0; i < 4; i++) w_s[i] = '0;
    if (s3_mode_r) begin
      w_s[1] = $signed(COEF_W'(ONE_D - DW'(s3_t_r)));
      w_s[2] = $signed(COEF_W'(s3_t_r));
    end else begin
      for (int i = 0; i < 3; i++) begin
        w_s[i] = round_sat(poly(NEAR_MASK[i], s3_cube_r[i], s3_sq_r[i], s3_acube_r[i],
                                s3_asq_r[i], s3_alin_r[i], s3_a_r));
      end
      // Normalised W3 absorbs rounding error so the set sums exactly to ONE.
      w_s[3] = NORM ? sat(ONE_ACC - (ACC_W'(w_s[0]) + ACC_W'(w_s[1]) + ACC_W'(w_s[2])))
                    : round_sat(poly(NEAR_MASK[3], s3_cube_r[3], s3_sq_r[3], s3_acube_r[3],
                                     s3_asq_r[3], s3_alin_r[3], s3_a_r));
    end
  end

  // Stage 4 register: weights update only with a valid set, so bubbles keep the last set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_w0    <= '0;
      out_w1    <= '0;
      out_w2    <= '0;
      out_w3    <= '0;
    end else if (adv_s) begin
      out_valid <= s3_v_r;
      if (s3_v_r) begin
        out_w0 <= w_s[0];
        out_w1 <= w_s[1];
        out_w2 <= w_s[2];
        out_w3 <= w_s[3];
      end
    end
  end

endmodule
